mem_access_ctrl: RTL and testbench

Initiator side of the unified single-port instruction/data memory. Sits between the core's fetch stage and load/store stage and the memory port. Arbitrates one access per memory cycle, drives the phase select (instruction vs. data half), address, read/write strobes and func3. Registers returned data and sign-extends `lb`/`lh` results, because the memory only returns zero-extended bytes and halves.

---
 rtl/mem_access_ctrl_pkg.sv | 27 ++
 rtl/mem_access_ctrl_if.sv | 38 +++
 rtl/mem_access_ctrl_load_extend.sv | 22 ++
 rtl/mem_access_ctrl.sv | 156 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and helpers for the unified instruction/data memory initiator.
// Holds the func3 encodings, controller state enum and access-size lookup.
package femto_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } mac_state_t;

  // Bytes touched by a load/store; 0 marks an encoding with no legal access.
  function automatic logic [2:0] access_size(input logic [2:0] func3);
    case (func3)
      F3_B, F3_BU: access_size = 3'd1;
      F3_H, F3_HU: access_size = 3'd2;
      F3_W:        access_size = 3'd4;
      default:     access_size = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Core-side fetch/data handshakes and the single memory port, bundled together.
// master = the access controller, slave = core plus memory.
interface mem_access_ctrl_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_instr;
  logic        if_err;

  logic        d_req;
  logic        d_we;
  logic [2:0]  d_func3;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        d_err;

  logic        mem_phase;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_func3;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_func3, d_addr, d_wdata, mem_rdata,
    output if_ready, if_instr, if_err, d_ready, d_rdata, d_err,
           mem_phase, mem_addr, mem_read, mem_write, mem_func3, mem_wdata
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_func3, d_addr, d_wdata, mem_rdata,
    input  if_ready, if_instr, if_err, d_ready, d_rdata, d_err,
           mem_phase, mem_addr, mem_read, mem_write, mem_func3, mem_wdata
  );
endinterface

// File: rtl/mem_access_ctrl_load_extend.sv
// Extends zero-extended byte/half memory data to the RV32 load result.
// Purely combinational so the writeback stage can reuse it.
module load_extend
  import femto_mem_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  always_comb begin
    ext = raw;
    case (func3)
      F3_B:    ext = {{24{raw[7]}}, raw[7:0]};
      F3_H:    ext = {{16{raw[15]}}, raw[15:0]};
      F3_BU:   ext = {24'h0, raw[7:0]};
      F3_HU:   ext = {16'h0, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Arbitrates fetch and load/store requests onto the single-port unified memory.
// state | meaning
// IDLE  | sample requests, arbitrate, answer illegal requests directly
// FETCH | instruction-half read cycle, capture word at closing edge
// DATA  | data-half load/store cycle, capture extended load data
module mem_access_ctrl
  import femto_mem_pkg::*;
#(
  parameter int DATA_BYTES  = 512,
  parameter int INSTR_BYTES = 512
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_ctrl_if.master  bus
);

  mac_state_t  state_q, state_d;
  logic        rr_fetch_last_q, rr_fetch_last_d;
  logic        if_ready_q, if_ready_d;
  logic        if_err_q, if_err_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        d_ready_q, d_ready_d;
  logic        d_err_q, d_err_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic        f_pend, d_pend, pick_fetch, pick_data;
  logic        f_bad, d_bad, f3_ok, align_ok;
  logic [2:0]  d_size;
  logic [32:0] d_end;
  logic [31:0] ext_rdata;

  load_extend u_load_extend (
    .func3 (bus.d_func3),
    .raw   (bus.mem_rdata),
    .ext   (ext_rdata)
  );

  // A port whose ready is high is still holding the request just answered.
  always_comb begin
    f_pend     = bus.if_req && !if_ready_q;
    d_pend     = bus.d_req && !d_ready_q;
    pick_fetch = f_pend && (!d_pend || !rr_fetch_last_q);
    pick_data  = d_pend && !pick_fetch;

    f_bad = (bus.if_addr[1:0] != 2'b00) || (bus.if_addr > 32'(INSTR_BYTES - 4));

    d_size = access_size(bus.d_func3);
    if (bus.d_we) begin
      f3_ok = (bus.d_func3 == F3_B) || (bus.d_func3 == F3_H) || (bus.d_func3 == F3_W);
    end else begin
      f3_ok = (d_size != 3'd0);
    end

    case (bus.d_func3)
      F3_W:       align_ok = (bus.d_addr[1:0] == 2'b00);
      F3_H, F3_HU: align_ok = !bus.d_addr[0];
      default:    align_ok = 1'b1;
    endcase

    // 33-bit sum so offsets near 2^32 cannot wrap into range.
    d_end = {1'b0, bus.d_addr} + {30'h0, d_size};
    d_bad = !f3_ok || !align_ok || (d_end > 33'(DATA_BYTES));
  end

  always_comb begin
    state_d         = state_q;
    rr_fetch_last_d = rr_fetch_last_q;
    if_ready_d      = 1'b0;
    if_err_d        = 1'b0;
    if_instr_d      = if_instr_q;
    d_ready_d       = 1'b0;
    d_err_d         = 1'b0;
    d_rdata_d       = d_rdata_q;
    bus.mem_phase   = 1'b0;
    bus.mem_addr    = 32'h0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_func3   = 3'b000;
    bus.mem_wdata   = 32'h0;

    case (state_q)
      IDLE: begin
        if (pick_fetch) begin
          rr_fetch_last_d = 1'b1;
          if (f_bad) begin
            if_ready_d = 1'b1;
            if_err_d   = 1'b1;
            if_instr_d = 32'h0;
          end else begin
            state_d = FETCH;
          end
        end else if (pick_data) begin
          rr_fetch_last_d = 1'b0;
          if (d_bad) begin
            d_ready_d = 1'b1;
            d_err_d   = 1'b1;
            d_rdata_d = 32'h0;
          end else begin
            state_d = DATA;
          end
        end
      end

      FETCH: begin
        bus.mem_phase = 1'b1;
        bus.mem_addr  = bus.if_addr;
        if_instr_d    = bus.mem_rdata;
        if_ready_d    = 1'b1;
        state_d       = IDLE;
      end

      DATA: begin
        bus.mem_addr  = bus.d_addr;
        bus.mem_func3 = bus.d_func3;
        bus.mem_read  = !bus.d_we;
        bus.mem_write = bus.d_we;
        bus.mem_wdata = bus.d_wdata;
        d_rdata_d     = bus.d_we ? 32'h0 : ext_rdata;
        d_ready_d     = 1'b1;
        state_d       = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      rr_fetch_last_q <= 1'b1;
      if_ready_q      <= 1'b0;
      if_err_q        <= 1'b0;
      if_instr_q      <= 32'h0;
      d_ready_q       <= 1'b0;
      d_err_q         <= 1'b0;
      d_rdata_q       <= 32'h0;
    end else begin
      state_q         <= state_d;
      rr_fetch_last_q <= rr_fetch_last_d;
      if_ready_q      <= if_ready_d;
      if_err_q        <= if_err_d;
      if_instr_q      <= if_instr_d;
      d_ready_q       <= d_ready_d;
      d_err_q         <= d_err_d;
      d_rdata_q       <= d_rdata_d;
    end
  end

  assign bus.if_ready = if_ready_q;
  assign bus.if_err   = if_err_q;
  assign bus.if_instr = if_instr_q;
  assign bus.d_ready  = d_ready_q;
  assign bus.d_err    = d_err_q;
  assign bus.d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a byte-array model of both memory halves.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mem_access_ctrl_if bus();

  mem_access_ctrl #(.DATA_BYTES(512), .INSTR_BYTES(512)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] imem [0:511];
  logic [7:0] dmem [0:511];
  logic [8:0] ma, ma1, ma2, ma3;

  assign ma  = bus.mem_addr[8:0];
  assign ma1 = ma + 9'd1;
  assign ma2 = ma + 9'd2;
  assign ma3 = ma + 9'd3;

  // Memory returns bytes and halves zero-extended; writes land at the clock edge.
  always_comb begin
    bus.mem_rdata = 32'h0;
    if (bus.mem_phase) begin
      bus.mem_rdata = {imem[ma3], imem[ma2], imem[ma1], imem[ma]};
    end else if (bus.mem_read) begin
      case (bus.mem_func3)
        3'b000, 3'b100: bus.mem_rdata = {24'h0, dmem[ma]};
        3'b001, 3'b101: bus.mem_rdata = {16'h0, dmem[ma1], dmem[ma]};
        default:        bus.mem_rdata = {dmem[ma3], dmem[ma2], dmem[ma1], dmem[ma]};
      endcase
    end
  end

  always @(posedge clk) begin
    if (bus.mem_write) begin
      dmem[ma] = bus.mem_wdata[7:0];
      if (bus.mem_func3 != 3'b000) dmem[ma1] = bus.mem_wdata[15:8];
      if (bus.mem_func3 == 3'b010) begin
        dmem[ma2] = bus.mem_wdata[23:16];
        dmem[ma3] = bus.mem_wdata[31:24];
      end
    end
  end

  task automatic data_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output logic err,
                          output int lat, output logic strobe);
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = we; bus.d_func3 = f3; bus.d_addr = addr; bus.d_wdata = wd;
    lat = 0; strobe = 1'b0;
    do begin
      @(posedge clk); @(negedge clk);
      lat++;
      if (bus.mem_read || bus.mem_write) strobe = 1'b1;
    end while (!bus.d_ready && lat < 10);
    if (!bus.d_ready) lat = 99;
    rd = bus.d_rdata; err = bus.d_err;
    bus.d_req = 1'b0;
  endtask

  task automatic fetch_txn(input logic [31:0] addr, output logic [31:0] instr, output logic err,
                           output int lat, output logic phase_seen);
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = addr;
    lat = 0; phase_seen = 1'b0;
    do begin
      @(posedge clk); @(negedge clk);
      lat++;
      if (bus.mem_phase) phase_seen = 1'b1;
    end while (!bus.if_ready && lat < 10);
    if (!bus.if_ready) lat = 99;
    instr = bus.if_instr; err = bus.if_err;
    bus.if_req = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({bus.if_ready, bus.d_ready, bus.if_err, bus.d_err} !== 4'b0) begin
      n_bad++; $display("FAIL reset_ready_err: got %b want 0000", {bus.if_ready, bus.d_ready, bus.if_err, bus.d_err});
    end
    n_cmp++;
    if ({bus.mem_phase, bus.mem_read, bus.mem_write} !== 3'b0 || bus.mem_addr !== 32'h0) begin
      n_bad++; $display("FAIL reset_mem_port: got ph/rd/wr %b addr %h want 000 / 0", {bus.mem_phase, bus.mem_read, bus.mem_write}, bus.mem_addr);
    end
    n_cmp++;
    if (bus.if_instr !== 32'h0 || bus.d_rdata !== 32'h0) begin
      n_bad++; $display("FAIL reset_data: got instr %h rdata %h want 0 / 0", bus.if_instr, bus.d_rdata);
    end
  endtask

  task automatic test_fetch();
    logic [31:0] ins; logic err; int lat; logic ph;
    fetch_txn(32'h4, ins, err, lat, ph);
    n_cmp++;
    if (ins !== 32'h00402303 || err !== 1'b0) begin
      n_bad++; $display("FAIL fetch4: got %h err %b want 00402303 err 0", ins, err);
    end
    n_cmp++;
    if (lat !== 2 || ph !== 1'b1) begin
      n_bad++; $display("FAIL fetch4_timing: got lat %0d phase %b want 2 / 1", lat, ph);
    end
    fetch_txn(32'h1FC, ins, err, lat, ph);
    n_cmp++;
    if (ins !== 32'hDEADBEEF || err !== 1'b0 || lat !== 2) begin
      n_bad++; $display("FAIL fetch_last: got %h err %b lat %0d want deadbeef 0 2", ins, err, lat);
    end
    fetch_txn(32'h2, ins, err, lat, ph);
    n_cmp++;
    if (ins !== 32'h0 || err !== 1'b1 || lat !== 1 || ph !== 1'b0) begin
      n_bad++; $display("FAIL fetch_misalign: got %h err %b lat %0d ph %b want 0 1 1 0", ins, err, lat, ph);
    end
    fetch_txn(32'h200, ins, err, lat, ph);
    n_cmp++;
    if (err !== 1'b1 || lat !== 1 || ph !== 1'b0) begin
      n_bad++; $display("FAIL fetch_range: got err %b lat %0d ph %b want 1 1 0", err, lat, ph);
    end
  endtask

  task automatic test_load();
    logic [31:0] rd; logic err; int lat; logic st;
    data_txn(1'b0, 3'b010, 32'd0, 32'h0, rd, err, lat, st);
    n_cmp++;
    if (rd !== 32'd17 || err !== 1'b0 || lat !== 2 || st !== 1'b1) begin
      n_bad++; $display("FAIL lw0: got %h err %b lat %0d strobe %b want 00000011 0 2 1", rd, err, lat, st);
    end
    data_txn(1'b0, 3'b000, 32'd12, 32'h0, rd, err, lat, st);
    n_cmp++;
    if (rd !== 32'hFFFFFF80 || err !== 1'b0) begin
      n_bad++; $display("FAIL lb12: got %h err %b want ffffff80 0", rd, err);
    end
    data_txn(1'b0, 3'b100, 32'd12, 32'h0, rd, err, lat, st);
    n_cmp++;
    if (rd !== 32'h00000080 || err !== 1'b0) begin
      n_bad++; $display("FAIL lbu12: got %h err %b want 00000080 0", rd, err);
    end
    data_txn(1'b0, 3'b010, 32'd508, 32'h0, rd, err, lat, st);
    n_cmp++;
    if (rd !== 32'h44332211 || err !== 1'b0 || lat !== 2) begin
      n_bad++; $display("FAIL lw508: got %h err %b lat %0d want 44332211 0 2", rd, err, lat);
    end
    data_txn(1'b0, 3'b100, 32'd511, 32'h0, rd, err, lat, st);
    n_cmp++;
    if (rd !== 32'h00000044 || err !== 1'b0) begin
      n_bad++; $display("FAIL lbu511: got %h err %b want 00000044 0", rd, err);
    end
  endtask

  task automatic test_store_half();
    logic [31:0] rd; logic err; int lat; logic st;
    data_txn(1'b1, 3'b001, 32'd8, 32'h1234ABCD, rd, err, lat, st);
    n_cmp++;
    if (rd !== 32'h0 || err !== 1'b0 || lat !== 2 || st !== 1'b1) begin
      n_bad++; $display("FAIL sh8: got %h err %b lat %0d strobe %b want 0 0 2 1", rd, err, lat, st);
    end
    data_txn(1'b0, 3'b101, 32'd8, 32'h0, rd, err, lat, st);
    n_cmp++;
    if (rd !== 32'h0000ABCD) begin
      n_bad++; $display("FAIL lhu8: got %h want 0000abcd", rd);
    end
    data_txn(1'b0, 3'b001, 32'd8, 32'h0, rd, err, lat, st);
    n_cmp++;
    if (rd !== 32'hFFFFABCD) begin
      n_bad++; $display("FAIL lh8: got %h want ffffabcd", rd);
    end
    data_txn(1'b0, 3'b010, 32'd8, 32'h0, rd, err, lat, st);
    n_cmp++;
    if (rd !== 32'h0000ABCD) begin
      n_bad++; $display("FAIL lw8_after_sh: got %h want 0000abcd", rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err; int lat; logic st;
    logic        e_we   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  e_f3   [8] = '{3'b010, 3'b001, 3'b011, 3'b010, 3'b010, 3'b100, 3'b101, 3'b000};
    logic [31:0] e_addr [8] = '{32'd6, 32'd3, 32'd0, 32'd510, 32'd512, 32'd4, 32'd511, 32'd512};
    for (int i = 0; i < 8; i++) begin
      data_txn(e_we[i], e_f3[i], e_addr[i], 32'hFFFFFFFF, rd, err, lat, st);
      n_cmp++;
      if (err !== 1'b1 || rd !== 32'h0 || lat !== 1 || st !== 1'b0) begin
        n_bad++;
        $display("FAIL err_case%0d: got err %b rdata %h lat %0d strobe %b want 1 0 1 0", i, err, rd, lat, st);
      end
    end
    data_txn(1'b0, 3'b010, 32'd4, 32'h0, rd, err, lat, st);
    n_cmp++;
    if (rd !== 32'h0 || err !== 1'b0) begin
      n_bad++; $display("FAIL illegal_store_no_write: got %h err %b want 0 0", rd, err);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] dr_vec, ir_vec, busy_vec;
    int bad_wr;
    logic [31:0] rd; logic err; int lat; logic st;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); @(negedge clk); rst = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h4;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_func3 = 3'b010; bus.d_addr = 32'd16; bus.d_wdata = 32'hCAFEF00D;
    dr_vec = '0; ir_vec = '0; busy_vec = '0; bad_wr = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); @(negedge clk);
      dr_vec[k]   = bus.d_ready;
      ir_vec[k]   = bus.if_ready;
      busy_vec[k] = bus.mem_phase | bus.mem_read | bus.mem_write;
      if (bus.mem_phase && bus.mem_write) bad_wr++;
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    n_cmp++;
    if (dr_vec !== 8'h22) begin
      n_bad++; $display("FAIL b2b_d_ready: got %b want 00100010", dr_vec);
    end
    n_cmp++;
    if (ir_vec !== 8'h88) begin
      n_bad++; $display("FAIL b2b_if_ready: got %b want 10001000", ir_vec);
    end
    n_cmp++;
    if (busy_vec !== 8'h55) begin
      n_bad++; $display("FAIL b2b_mem_busy: got %b want 01010101", busy_vec);
    end
    n_cmp++;
    if (bad_wr !== 0) begin
      n_bad++; $display("FAIL b2b_write_in_fetch: got %0d cycles want 0", bad_wr);
    end
    data_txn(1'b0, 3'b010, 32'd16, 32'h0, rd, err, lat, st);
    n_cmp++;
    if (rd !== 32'hCAFEF00D) begin
      n_bad++; $display("FAIL b2b_store_data: got %h want cafef00d", rd);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rd; logic err; int lat; logic st;
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_func3 = 3'b010; bus.d_addr = 32'd0;
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if (bus.mem_read !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_in_data: got mem_read %b want 1", bus.mem_read);
    end
    rst = 1'b1; bus.d_req = 1'b0;
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if (bus.d_ready !== 1'b0 || bus.d_rdata !== 32'h0 || bus.if_instr !== 32'h0) begin
      n_bad++; $display("FAIL rstmid_outputs: got ready %b rdata %h instr %h want 0 0 0", bus.d_ready, bus.d_rdata, bus.if_instr);
    end
    n_cmp++;
    if ({bus.mem_phase, bus.mem_read, bus.mem_write} !== 3'b0 || bus.mem_addr !== 32'h0) begin
      n_bad++; $display("FAIL rstmid_mem_port: got %b addr %h want 000 0", {bus.mem_phase, bus.mem_read, bus.mem_write}, bus.mem_addr);
    end
    rst = 1'b0;
    data_txn(1'b0, 3'b010, 32'd0, 32'h0, rd, err, lat, st);
    n_cmp++;
    if (rd !== 32'd17 || err !== 1'b0 || lat !== 2) begin
      n_bad++; $display("FAIL rstmid_recover: got %h err %b lat %0d want 00000011 0 2", rd, err, lat);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      imem[i] = 8'h0;
      dmem[i] = 8'h0;
    end
    {imem[7], imem[6], imem[5], imem[4]} = 32'h00402303;
    {imem[511], imem[510], imem[509], imem[508]} = 32'hDEADBEEF;
    {dmem[3], dmem[2], dmem[1], dmem[0]} = 32'd17;
    dmem[12] = 8'h80;
    {dmem[511], dmem[510], dmem[509], dmem[508]} = 32'h44332211;
    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_func3 = 3'b000; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    test_reset();
    test_fetch();
    test_load();
    test_store_half();
    test_errors();
    test_back_to_back();
    test_reset_mid_access();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
